// File: rtl/sensor_frame_serializer.sv
// Sensor framer: takes a DATA_W sample on valid/ready, builds
// {parity, [seq], data, HEADER} and shifts it out LSB first.
// After each frame it holds GAP_CYCLES idle cycles.
// Optional feature: define SENSOR_SEQ_NUM_EN to insert a SEQ_W
// sequence counter between parity and data (covered by parity).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   data_in[DATA_W]      sample
//   data_in_valid        sample present
//   data_in_ready        block accepts (IDLE only)
//   data_out             serial frame bit (0 when not valid)
//   data_valid           data_out carries a frame bit
//   frame_start          pulse with the first header bit
//   busy                 high while sending or in the gap
module sensor_frame_serializer #(
    parameter int              DATA_W     = 8,
    parameter int              HDR_W      = 3,
    parameter logic [HDR_W-1:0] HEADER    = 3'b101,
    parameter int              GAP_CYCLES = 4,
    parameter bit              PARITY_ODD = 1'b0,
    parameter int              SEQ_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic              data_out,
    output logic              data_valid,
    output logic              frame_start,
    output logic              busy
);

`ifdef SENSOR_SEQ_NUM_EN
    localparam int SEQ_BITS = SEQ_W;
`else
    // no counter: the seq field collapses to zero width
    localparam int SEQ_BITS = 0 * SEQ_W;
`endif

    localparam int PAY_W   = DATA_W + SEQ_BITS;
    localparam int FRAME_W = HDR_W + PAY_W + 1;
    localparam int CNT_MAX = (FRAME_W > GAP_CYCLES) ? FRAME_W : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_d, dout_d, dv_d, fs_d, busy_d;

    logic [PAY_W-1:0]   payload;
    logic               parity;
    logic [FRAME_W-1:0] frame;
    logic               accept;

    assign accept = (state_q == S_IDLE) & data_in_valid & data_in_ready;

`ifdef SENSOR_SEQ_NUM_EN
    logic [SEQ_W-1:0] seq_q;

    // frame carries the current count; advance once it is latched
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q <= '0;
        end else if (accept) begin
            seq_q <= seq_q + SEQ_W'(1);
        end
    end

    assign payload = {seq_q, data_in};
`else
    assign payload = data_in;
`endif

    assign parity = PARITY_ODD ? ~^payload : ^payload;
    assign frame  = {parity, payload, HEADER};

    // cnt_q counts frame bits already on the wire in SEND,
    // and elapsed gap cycles in GAP
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        dout_d  = 1'b0;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
        busy_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    state_d = S_SEND;
                    // bit 0 goes out straight away; the rest waits
                    shreg_d = frame >> 1;
                    cnt_d   = CNT_W'(1);
                    dout_d  = frame[0];
                    dv_d    = 1'b1;
                    fs_d    = 1'b1;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            S_SEND: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(FRAME_W)) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    dout_d  = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    dv_d    = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(GAP_CYCLES)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            data_in_ready <= 1'b1;
            data_out      <= 1'b0;
            data_valid    <= 1'b0;
            frame_start   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            data_in_ready <= ready_d;
            data_out      <= dout_d;
            data_valid    <= dv_d;
            frame_start   <= fs_d;
            busy          <= busy_d;
        end
    end

endmodule
